// File: rtl/pc_gen_if.sv
// Bus bundle between the fetch/hazard/execute logic and the PC generator.
// The master drives the enable and redirect request and observes the PC state.
// The slave (pc_gen) consumes that request and drives the PC state.
interface pc_gen_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   en;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic [31:0]            pc;
  logic [31:0]            pc_next;
  logic                   flush;
  logic                   misalign_err;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output en, redirect_valid, redirect_pc,
    input  pc, pc_next, flush, misalign_err, stall_cnt
  );

  modport slave (
    input  en, redirect_valid, redirect_pc,
    output pc, pc_next, flush, misalign_err, stall_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator with deferred redirects and halt on a misaligned target.
// Optional macro PC_GEN_STALL_CNT_EN builds the saturating stall counter;
// when it is undefined, stall_cnt is tied to zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch: pc advances by 4 or takes a redirect when en=1
// PEND  | a redirect arrived while stalled; target is held in pend_pc_q
// HALT  | a misaligned target was seen; frozen until rst
module pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.slave   bus
);

  typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic        flush_q;
  logic        misalign_q;
  logic [31:0] pc_d;
  logic        redir_ok;
  logic        redir_bad;

  assign redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  // Next fetch address: a fresh aligned redirect beats a pending target,
  // which beats sequential fetch. It is also the value pc loads when en=1.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (rst) begin
      pc_d = RESET_PC;
    end else if (state_q == HALT) begin
      pc_d = pc_q;
    end else if (redir_ok) begin
      pc_d = bus.redirect_pc;
    end else if (state_q == PEND) begin
      pc_d = pend_pc_q;
    end
  end

  // Control FSM with registered pc, pending target, flush and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0000_0000;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          if (redir_bad) begin
            // Misaligned target is never fetched; pc freezes where it is.
            state_q    <= HALT;
            misalign_q <= 1'b1;
          end else if (bus.en) begin
            pc_q    <= pc_d;
            flush_q <= redir_ok || (state_q == PEND);
            state_q <= RUN;
          end else if (redir_ok) begin
            // Stalled: remember the newest target until fetch may advance.
            pend_pc_q <= bus.redirect_pc;
            state_q   <= PEND;
          end
        end
      endcase
    end
  end

`ifdef PC_GEN_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Count stalled cycles outside HALT, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!bus.en && (state_q != HALT) && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = {STALL_CNT_W{1'b0}};
`endif

  assign bus.pc           = pc_q;
  assign bus.pc_next      = pc_d;
  assign bus.flush        = flush_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the PC rules.
module tb_pc_gen;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          SW       = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pc_gen_if #(.STALL_CNT_W(SW)) bus ();

  pc_gen #(.RESET_PC(RESET_PC), .STALL_CNT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain description of where the program counter is,
  // whether a target is waiting, and whether the block has halted.
  logic [31:0]   m_pc;
  logic          m_has_pend;
  logic [31:0]   m_pend_pc;
  logic          m_halted;
  logic          m_flush;
  logic          m_err;
  int unsigned   m_stalls;

  function automatic logic [31:0] model_next();
    if (rst) return RESET_PC;
    if (m_halted) return m_pc;
    if (bus.redirect_valid && bus.redirect_pc[1:0] == 2'b00) return bus.redirect_pc;
    if (m_has_pend) return m_pend_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_has_pend = 0; m_pend_pc = 0; m_halted = 0;
    m_flush = 0; m_err = 0; m_stalls = 0;
  endtask

  task automatic model_edge();
    logic aligned, bad;
    if (rst) begin
      model_reset();
      return;
    end
    aligned = bus.redirect_valid && bus.redirect_pc[1:0] == 2'b00;
    bad     = bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00;
    if (!bus.en && !m_halted && m_stalls < (2**SW - 1)) m_stalls++;
    m_flush = 0;
    if (m_halted) begin
      // frozen
    end else if (bad) begin
      m_halted = 1;
      m_err    = 1;
    end else if (bus.en) begin
      if (aligned) begin
        m_pc = bus.redirect_pc; m_flush = 1;
      end else if (m_has_pend) begin
        m_pc = m_pend_pc; m_flush = 1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_has_pend = 0;
    end else if (aligned) begin
      m_has_pend = 1;
      m_pend_pc  = bus.redirect_pc;
    end
  endtask

  function automatic logic [31:0] exp_stall();
`ifdef PC_GEN_STALL_CNT_EN
    return 32'(m_stalls);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check pc_next mid-cycle, clock the model, check registers.
  task automatic cycle(input logic r, input logic e, input logic v, input logic [31:0] t);
    rst = r; bus.en = e; bus.redirect_valid = v; bus.redirect_pc = t;
    @(negedge clk);
    chk("pc_next", bus.pc_next, model_next());
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", bus.pc, m_pc);
    chk("flush", {31'd0, bus.flush}, {31'd0, m_flush});
    chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});
    chk("stall_cnt", {{(32-SW){1'b0}}, bus.stall_cnt}, exp_stall());
  endtask

  initial begin
    logic        r, e, v;
    logic [31:0] t;
    rst = 1; bus.en = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    @(posedge clk); #1;
    model_reset();

    // Reset state
    cycle(1, 0, 0, 0);
    chk("reset_pc", bus.pc, RESET_PC);
    chk("reset_flush", {31'd0, bus.flush}, 32'd0);

    // Sequential fetch after reset release
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0);
      chk("seq_pc", bus.pc, 32'(4 * (i + 1)));
      chk("seq_flush", {31'd0, bus.flush}, 32'd0);
    end

    // Immediate redirect at pc=8
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("pc_before_redirect", bus.pc, 32'h8);
    cycle(0, 1, 1, 32'h40);
    chk("redirect_pc", bus.pc, 32'h40);
    chk("redirect_flush", {31'd0, bus.flush}, 32'd1);
    bus.redirect_valid = 0;
    #1;
    chk("pc_next_after_redirect", bus.pc_next, 32'h44);
    cycle(0, 1, 0, 0);
    chk("flush_one_cycle", {31'd0, bus.flush}, 32'd0);

    // Deferred redirects while stalled, newest wins
    cycle(0, 0, 1, 32'h80);
    chk("pend_hold1", bus.pc, 32'h44);
    cycle(0, 0, 1, 32'h100);
    chk("pend_hold2", bus.pc, 32'h44);
    cycle(0, 0, 0, 0);
    chk("pend_hold3", bus.pc, 32'h44);
    cycle(0, 1, 0, 0);
    chk("pend_release_pc", bus.pc, 32'h100);
    chk("pend_release_flush", {31'd0, bus.flush}, 32'd1);
    cycle(0, 1, 0, 0);
    chk("pend_flush_once", {31'd0, bus.flush}, 32'd0);

    // Misaligned target halts until reset
    cycle(0, 1, 1, 32'h42);
    chk("halt_err", {31'd0, bus.misalign_err}, 32'd1);
    chk("halt_pc", bus.pc, 32'h104);
    cycle(0, 1, 1, 32'h300);
    chk("halt_frozen", bus.pc, 32'h104);
    cycle(1, 1, 0, 0);
    chk("halt_rst_pc", bus.pc, RESET_PC);
    chk("halt_rst_err", {31'd0, bus.misalign_err}, 32'd0);

    // Wrap at top of address space, then stall count
    cycle(0, 1, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 0, 0);
    chk("wrap_pc", bus.pc, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
`ifdef PC_GEN_STALL_CNT_EN
    chk("stall_three", {{(32-SW){1'b0}}, bus.stall_cnt}, 32'd3);
`else
    chk("stall_three", {{(32-SW){1'b0}}, bus.stall_cnt}, 32'd0);
`endif

    // Reset while a target is pending discards it
    cycle(0, 0, 1, 32'h200);
    cycle(1, 1, 0, 0);
    chk("pend_rst_pc", bus.pc, RESET_PC);
    chk("pend_rst_flush", {31'd0, bus.flush}, 32'd0);
    cycle(0, 1, 0, 0);
    chk("pend_lost_pc", bus.pc, RESET_PC + 32'd4);
    chk("pend_lost_flush", {31'd0, bus.flush}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 3) == 0);
      t = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 39) == 0) t[1:0] = 2'($urandom_range(1, 3));
      cycle(r, e, v, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of the stall counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the fetch memory downstream samples on the falling edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  advance enable from the fetch/hazard stage; 0 = hold the PC.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken, one-cycle pulse from execute.
REQ-007 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-008 SHALL have port pc  output  32  registered address of the current fetch.
REQ-009 SHALL have port pc_next  output  32  combinational address of the next fetch, consumed by the fetch stage for look-ahead hazard checks.
REQ-010 SHALL have port flush  output  1  registered one-cycle pulse that squashes the wrong-path instruction in IF/ID.
REQ-011 SHALL have port misalign_err  output  1  sticky error flag for a misaligned target.
REQ-012 SHALL have port stall_cnt  output  STALL_CNT_W  saturating count of stalled cycles.

Function
REQ-013 SHALL implement the states RUN, PEND and HALT.
REQ-014 In RUN with en=1 and no redirect, pc SHALL become pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-015 In RUN with en=1 and redirect_valid=1 with redirect_pc[1:0]==0, pc SHALL become redirect_pc on the same edge, and flush SHALL be 1 for the following cycle.
REQ-016 In RUN with en=0 and a valid redirect, the block SHALL latch the target into pend_pc, go to PEND, and hold pc.
REQ-017 In PEND, a new valid redirect SHALL overwrite pend_pc (newest target wins).
REQ-018 In PEND with en=1, pc SHALL load pend_pc (or redirect_pc if a redirect arrives on that edge), state SHALL return to RUN, and flush SHALL pulse one cycle.
REQ-019 pc_next SHALL equal, in priority order: redirect_pc if redirect_valid=1 and aligned; otherwise pend_pc in PEND; otherwise pc+4.
REQ-020 A redirect with redirect_pc[1:0]!=0 SHALL be ignored for pc, SHALL set misalign_err, and SHALL move the state to HALT from any state.
REQ-021 In HALT:
  - pc SHALL hold;
  - pc_next SHALL equal pc;
  - flush SHALL be 0;
  - the block SHALL leave HALT only via rst.
REQ-022 With en=0 and no redirect, pc, state and pend_pc SHALL hold.
REQ-023 flush SHALL never be asserted for two consecutive cycles unless two redirects are applied on consecutive edges.
REQ-024 stall_cnt SHALL increment on every rising edge with en=0 outside HALT, and SHALL saturate at all-ones.

Reset
REQ-025 On a rising edge with rst=1, the block SHALL set:
  - pc=RESET_PC;
  - state=RUN;
  - pend_pc=0;
  - flush=0;
  - misalign_err=0;
  - stall_cnt=0.
REQ-026 rst SHALL take priority over en and redirect_valid on the same edge, including mid-PEND (the pending target is discarded).
REQ-027 While rst=1, pc_next SHALL equal RESET_PC.

Configuration
REQ-028 With macro PC_GEN_STALL_CNT_EN defined, the stall counter SHALL be built and behave per REQ-024.
REQ-029 Without PC_GEN_STALL_CNT_EN, stall_cnt SHALL be tied to 0, no counter flops SHALL be generated, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Release rst with en=1 for 4 cycles -> pc sequence 0,4,8,12,16; flush=0 throughout.
REQ-031 At pc=8, en=1 and redirect to 32'h40 -> next pc=32'h40, flush=1 for exactly one cycle, pc_next=32'h44 afterwards.
REQ-032 With en=0, redirect to 32'h80, then redirect to 32'h100 a cycle later, then en=1 -> pc holds until en=1, then pc=32'h100 with one flush pulse.
REQ-033 Redirect to 32'h42 -> misalign_err=1, pc frozen, state HALT; then rst -> pc=RESET_PC and misalign_err=0.
REQ-034 Set pc=32'hFFFF_FFFC with en=1 -> pc=0; en=0 for 3 cycles -> stall_cnt=3 with the macro defined, 0 without.
REQ-035 Assert rst in PEND with a pending target 32'h200 -> pc=RESET_PC, the pending target is lost, and no flush occurs.
